// File: rtl/pe_mac_v2.sv
// pe_mac_v2 -- systolic processing element with a pipelined multiplier.
// Output-stationary (OS) mode accumulates locally and hands the sum out through
// a drain FSM with a valid/ready handshake. Weight-stationary (WS) mode adds the
// product to the partial sum arriving from the north and passes it south.
// Arithmetic is signed or unsigned and saturating or wrapping, set by parameters.
module pe_mac_v2 #(
    parameter int DATA_W   = 8,
    parameter int SUM_W    = 32,
    parameter int SIGNED   = 0,
    parameter int MUL_PIPE = 1,
    parameter int SATURATE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              mode,
    input  logic              w_load,
    input  logic              acc_clr,
    input  logic              drain,
    input  logic [DATA_W-1:0] a_in,
    input  logic              a_vld_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic [SUM_W-1:0]  psum_in,
    output logic [DATA_W-1:0] a_out,
    output logic              a_vld_out,
    output logic [DATA_W-1:0] b_out,
    output logic [SUM_W-1:0]  psum_out,
    output logic [SUM_W-1:0]  sum_out,
    output logic              sum_vld,
    input  logic              sum_rdy,
    output logic              sat_flag
);

    localparam int PROD_W = 2 * DATA_W;

    typedef enum logic [1:0] {
        ST_ACC   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // Widen the raw product to the sum width, honouring the operand signedness.
    function automatic logic [SUM_W-1:0] ext_prod(input logic [PROD_W-1:0] p);
        logic [SUM_W-1:0] r;
        if (SIGNED != 0) begin
            r = SUM_W'($signed(p));
        end else begin
            r = SUM_W'(p);
        end
        return r;
    endfunction

    // Add two sums; the MSB of the result is the overflow flag (only ever set
    // when saturating), the rest is the clamped or wrapped sum.
    function automatic logic [SUM_W:0] add_rule(input logic [SUM_W-1:0] x,
                                                input logic [SUM_W-1:0] y);
        logic [SUM_W:0]   raw;
        logic             ovf;
        logic [SUM_W-1:0] res;
        raw = {1'b0, x} + {1'b0, y};
        if (SIGNED != 0) begin
            ovf = (x[SUM_W-1] == y[SUM_W-1]) && (raw[SUM_W-1] != x[SUM_W-1]);
        end else begin
            ovf = raw[SUM_W];
        end
        if ((SATURATE != 0) && ovf) begin
            if (SIGNED != 0) begin
                res = x[SUM_W-1] ? {1'b1, {(SUM_W-1){1'b0}}} : {1'b0, {(SUM_W-1){1'b1}}};
            end else begin
                res = {SUM_W{1'b1}};
            end
        end else begin
            res = raw[SUM_W-1:0];
        end
        return {((SATURATE != 0) && ovf), res};
    endfunction

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    state_t              state_r;
    state_t              state_nxt_s;
    logic [1:0]          cnt_r;
    logic [1:0]          cnt_nxt_s;
    logic                flush_done_s;
    logic                hold_rel_s;
    logic                sum_vld_nxt_s;

    logic [DATA_W-1:0]   w_r;
    logic [PROD_W-1:0]   op_a_s;
    logic [PROD_W-1:0]   op_b_s;
    logic [PROD_W-1:0]   prod_s;
    logic [SUM_W-1:0]    prod_ext_s;
    logic                cap_v_s;

    logic                emerge_v_s;
    logic                emerge_m_s;
    logic [SUM_W-1:0]    emerge_p_s;
    logic                use_os_s;
    logic                use_ws_s;
    logic [SUM_W:0]      os_add_s;
    logic [SUM_W:0]      ws_add_s;

    logic [SUM_W-1:0]    acc_r;
    logic                sat_r;
    logic [SUM_W-1:0]    psum_r;
    logic                sum_vld_r;
    logic [DATA_W-1:0]   a_r;
    logic                a_vld_r;
    logic [DATA_W-1:0]   b_r;

    // ------------------------------------------------------------------
    // Multiplier front end
    // ------------------------------------------------------------------

    // Form the product from the west operand and either the stored weight or b_in.
    always_comb begin
        op_a_s = {PROD_W{1'b0}};
        op_b_s = {PROD_W{1'b0}};
        if (SIGNED != 0) begin
            op_a_s = PROD_W'($signed(a_in));
            op_b_s = mode ? PROD_W'($signed(w_r)) : PROD_W'($signed(b_in));
        end else begin
            op_a_s = PROD_W'(a_in);
            op_b_s = mode ? PROD_W'(w_r) : PROD_W'(b_in);
        end
        prod_s     = op_a_s * op_b_s;
        prod_ext_s = ext_prod(prod_s);
    end

    // Capture is suppressed in OS mode while draining, except that a clear
    // restarts accumulation and takes the same-cycle operand as its first term.
    assign cap_v_s = a_vld_in & (mode | (state_r == ST_ACC) | acc_clr);

    generate
        if (MUL_PIPE == 0) begin : g_comb
            assign emerge_v_s = cap_v_s;
            assign emerge_m_s = mode;
            assign emerge_p_s = prod_ext_s;
        end else begin : g_pipe
            logic [SUM_W-1:0]    p_r [0:MUL_PIPE-1];
            logic [MUL_PIPE-1:0] v_r;
            logic [MUL_PIPE-1:0] m_r;

            // Advance products with their valid and mode tag; a clear drops in-flight ones.
            always_ff @(posedge clk) begin
                if (rst) begin
                    v_r <= {MUL_PIPE{1'b0}};
                    m_r <= {MUL_PIPE{1'b0}};
                    for (int i = 0; i < MUL_PIPE; i++) begin
                        p_r[i] <= {SUM_W{1'b0}};
                    end
                end else if (en) begin
                    v_r[0] <= cap_v_s;
                    m_r[0] <= mode;
                    p_r[0] <= prod_ext_s;
                    for (int i = 1; i < MUL_PIPE; i++) begin
                        v_r[i] <= acc_clr ? 1'b0 : v_r[i-1];
                        m_r[i] <= m_r[i-1];
                        p_r[i] <= p_r[i-1];
                    end
                end
            end

            assign emerge_v_s = v_r[MUL_PIPE-1] & ~acc_clr;
            assign emerge_m_s = m_r[MUL_PIPE-1];
            assign emerge_p_s = p_r[MUL_PIPE-1];
        end
    endgenerate

    assign use_os_s = emerge_v_s & ~emerge_m_s;
    assign use_ws_s = emerge_v_s & emerge_m_s;
    assign os_add_s = add_rule(acc_r, emerge_p_s);
    assign ws_add_s = add_rule(psum_in, emerge_p_s);

    // ------------------------------------------------------------------
    // Drain FSM
    // ------------------------------------------------------------------

    // State and flush counter register; frozen while en is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_ACC;
            cnt_r   <= 2'd0;
        end else if (en) begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end else begin
            state_r <= state_r;
            cnt_r   <= cnt_r;
        end
    end

    // Next-state logic; a clear overrides drain and sum_rdy.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = 2'd0;
        if (acc_clr) begin
            state_nxt_s = ST_ACC;
        end else begin
            case (state_r)
                ST_ACC: begin
                    if (drain && !mode) begin
                        state_nxt_s = ST_FLUSH;
                    end else begin
                        state_nxt_s = ST_ACC;
                    end
                end
                ST_FLUSH: begin
                    if (flush_done_s) begin
                        state_nxt_s = ST_HOLD;
                    end else begin
                        state_nxt_s = ST_FLUSH;
                        cnt_nxt_s   = cnt_r + 2'd1;
                    end
                end
                ST_HOLD: begin
                    if (sum_rdy) begin
                        state_nxt_s = ST_ACC;
                    end else begin
                        state_nxt_s = ST_HOLD;
                    end
                end
                default: begin
                    state_nxt_s = ST_ACC;
                end
            endcase
        end
    end

    // Output decode: flush length, handshake release and the next sum_vld value.
    always_comb begin
        flush_done_s  = ((32'(cnt_r) + 32'd1) >= 32'(MUL_PIPE));
        hold_rel_s    = 1'b0;
        sum_vld_nxt_s = 1'b0;
        if ((state_r == ST_HOLD) && sum_rdy && !acc_clr) begin
            hold_rel_s = 1'b1;
        end else begin
            hold_rel_s = 1'b0;
        end
        if (state_nxt_s == ST_HOLD) begin
            sum_vld_nxt_s = 1'b1;
        end else begin
            sum_vld_nxt_s = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------

    // Stationary weight; a same-cycle product still sees the previous value.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_r <= {DATA_W{1'b0}};
        end else if (en && w_load) begin
            w_r <= b_in;
        end
    end

    // OS accumulator and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r <= {SUM_W{1'b0}};
            sat_r <= 1'b0;
        end else if (en) begin
            if (acc_clr) begin
                acc_r <= use_os_s ? emerge_p_s : {SUM_W{1'b0}};
                sat_r <= 1'b0;
            end else if (hold_rel_s) begin
                acc_r <= {SUM_W{1'b0}};
                sat_r <= 1'b0;
            end else begin
                if (use_os_s) begin
                    acc_r <= os_add_s[SUM_W-1:0];
                end
                sat_r <= sat_r | (use_os_s & os_add_s[SUM_W]) | (use_ws_s & ws_add_s[SUM_W]);
            end
        end
    end

    // WS partial sum to the south; holds when no WS product emerges.
    always_ff @(posedge clk) begin
        if (rst) begin
            psum_r <= {SUM_W{1'b0}};
        end else if (en && use_ws_s) begin
            psum_r <= ws_add_s[SUM_W-1:0];
        end
    end

    // Registered readout valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_vld_r <= 1'b0;
        end else if (en) begin
            sum_vld_r <= sum_vld_nxt_s;
        end
    end

    // Operand forwarding to the east and south neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r     <= {DATA_W{1'b0}};
            a_vld_r <= 1'b0;
            b_r     <= {DATA_W{1'b0}};
        end else if (en) begin
            a_r     <= a_in;
            a_vld_r <= a_vld_in;
            b_r     <= b_in;
        end
    end

    assign a_out     = a_r;
    assign a_vld_out = a_vld_r;
    assign b_out     = b_r;
    assign psum_out  = psum_r;
    assign sum_out   = acc_r;
    assign sum_vld   = sum_vld_r;
    assign sat_flag  = sat_r;

endmodule

// File: tb/tb_pe_mac_v2.sv
// Directed bench for pe_mac_v2: five instances share one stimulus stream and
// each scenario checks the instance whose parameters it targets.
module tb_pe_mac_v2;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        mode;
    logic        w_load;
    logic        acc_clr;
    logic        drain;
    logic [7:0]  a_in;
    logic        a_vld_in;
    logic [7:0]  b_in;
    logic [31:0] psum_in;
    logic        sum_rdy;

    int checks = 0;
    int errors = 0;

    // base: unsigned, 32-bit, MUL_PIPE=1, saturating
    logic [7:0]  ba_out, bb_out;
    logic        ba_vld, b_vld, b_sat;
    logic [31:0] b_psum, b_sum;
    // signed variant
    logic [7:0]  sa_out, sb_out;
    logic        sa_vld, s_vld, s_sat;
    logic [31:0] s_psum, s_sum;
    // 16-bit saturating
    logic [7:0]  ta_out, tb_out;
    logic        ta_vld, t_vld, t_sat;
    logic [15:0] t_psum, t_sum;
    // 16-bit wrapping
    logic [7:0]  wa_out, wb_out;
    logic        wa_vld, w_vld, w_sat;
    logic [15:0] w_psum, w_sum;
    // MUL_PIPE=2
    logic [7:0]  pa_out, pb_out;
    logic        pa_vld, p_vld, p_sat;
    logic [31:0] p_psum, p_sum;

    always #5 clk = ~clk;

    pe_mac_v2 #(.DATA_W(8), .SUM_W(32), .SIGNED(0), .MUL_PIPE(1), .SATURATE(1)) u_base (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .w_load(w_load), .acc_clr(acc_clr),
        .drain(drain), .a_in(a_in), .a_vld_in(a_vld_in), .b_in(b_in), .psum_in(psum_in),
        .a_out(ba_out), .a_vld_out(ba_vld), .b_out(bb_out), .psum_out(b_psum),
        .sum_out(b_sum), .sum_vld(b_vld), .sum_rdy(sum_rdy), .sat_flag(b_sat));

    pe_mac_v2 #(.DATA_W(8), .SUM_W(32), .SIGNED(1), .MUL_PIPE(1), .SATURATE(1)) u_sgn (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .w_load(w_load), .acc_clr(acc_clr),
        .drain(drain), .a_in(a_in), .a_vld_in(a_vld_in), .b_in(b_in), .psum_in(psum_in),
        .a_out(sa_out), .a_vld_out(sa_vld), .b_out(sb_out), .psum_out(s_psum),
        .sum_out(s_sum), .sum_vld(s_vld), .sum_rdy(sum_rdy), .sat_flag(s_sat));

    pe_mac_v2 #(.DATA_W(8), .SUM_W(16), .SIGNED(0), .MUL_PIPE(1), .SATURATE(1)) u_s16 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .w_load(w_load), .acc_clr(acc_clr),
        .drain(drain), .a_in(a_in), .a_vld_in(a_vld_in), .b_in(b_in), .psum_in(psum_in[15:0]),
        .a_out(ta_out), .a_vld_out(ta_vld), .b_out(tb_out), .psum_out(t_psum),
        .sum_out(t_sum), .sum_vld(t_vld), .sum_rdy(sum_rdy), .sat_flag(t_sat));

    pe_mac_v2 #(.DATA_W(8), .SUM_W(16), .SIGNED(0), .MUL_PIPE(1), .SATURATE(0)) u_w16 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .w_load(w_load), .acc_clr(acc_clr),
        .drain(drain), .a_in(a_in), .a_vld_in(a_vld_in), .b_in(b_in), .psum_in(psum_in[15:0]),
        .a_out(wa_out), .a_vld_out(wa_vld), .b_out(wb_out), .psum_out(w_psum),
        .sum_out(w_sum), .sum_vld(w_vld), .sum_rdy(sum_rdy), .sat_flag(w_sat));

    pe_mac_v2 #(.DATA_W(8), .SUM_W(32), .SIGNED(0), .MUL_PIPE(2), .SATURATE(1)) u_mp2 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .w_load(w_load), .acc_clr(acc_clr),
        .drain(drain), .a_in(a_in), .a_vld_in(a_vld_in), .b_in(b_in), .psum_in(psum_in),
        .a_out(pa_out), .a_vld_out(pa_vld), .b_out(pb_out), .psum_out(p_psum),
        .sum_out(p_sum), .sum_vld(p_vld), .sum_rdy(sum_rdy), .sat_flag(p_sat));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; mode = 1'b0; w_load = 1'b0; acc_clr = 1'b0; drain = 1'b0;
        a_in = 8'hA5; a_vld_in = 1'b1; b_in = 8'h5A; psum_in = 32'd77; sum_rdy = 1'b0;
        step(); step();
        checks++; if ({ba_out, ba_vld, bb_out} !== 17'd0) begin
            $display("FAIL reset_fwd: got %h expected 0", {ba_out, ba_vld, bb_out}); errors++; end
        checks++; if ({b_sum, b_psum} !== 64'd0) begin
            $display("FAIL reset_sums: got %h expected 0", {b_sum, b_psum}); errors++; end
        checks++; if ({b_vld, b_sat} !== 2'b00) begin
            $display("FAIL reset_flags: got %b expected 00", {b_vld, b_sat}); errors++; end
        rst = 1'b0; a_vld_in = 1'b0; a_in = 8'd0; b_in = 8'd0; psum_in = 32'd0;
        step();
    endtask

    task automatic test_ws();
        mode = 1'b1; w_load = 1'b1; b_in = 8'd7; psum_in = 32'd100;
        step();
        w_load = 1'b0; b_in = 8'd9; a_in = 8'd2; a_vld_in = 1'b1;
        step();
        checks++; if (b_psum !== 32'd0) begin
            $display("FAIL ws_early: got %0d expected 0", b_psum); errors++; end
        checks++; if (bb_out !== 8'd9) begin
            $display("FAIL b_fwd: got %0d expected 9", bb_out); errors++; end
        a_vld_in = 1'b0;
        step();
        checks++; if (b_psum !== 32'd114) begin
            $display("FAIL ws_psum: got %0d expected 114", b_psum); errors++; end
        checks++; if (t_psum !== 16'd114) begin
            $display("FAIL ws_psum16: got %0d expected 114", t_psum); errors++; end
        checks++; if (p_psum !== 32'd0) begin
            $display("FAIL ws_mp2_early: got %0d expected 0", p_psum); errors++; end
        step();
        checks++; if (p_psum !== 32'd114) begin
            $display("FAIL ws_mp2: got %0d expected 114", p_psum); errors++; end
        checks++; if (b_psum !== 32'd114) begin
            $display("FAIL ws_hold: got %0d expected 114", b_psum); errors++; end
        // weight load with a same-cycle product: product uses the old weight 7
        w_load = 1'b1; b_in = 8'd3; a_in = 8'd2; a_vld_in = 1'b1; psum_in = 32'd0;
        step();
        w_load = 1'b0; a_vld_in = 1'b0;
        step();
        checks++; if (b_psum !== 32'd14) begin
            $display("FAIL ws_old_w: got %0d expected 14", b_psum); errors++; end
        checks++; if (b_sum !== 32'd0) begin
            $display("FAIL ws_no_acc: got %0d expected 0", b_sum); errors++; end
        a_in = 8'd4; a_vld_in = 1'b1; psum_in = 32'd1;
        step();
        a_vld_in = 1'b0;
        step();
        checks++; if (b_psum !== 32'd13) begin
            $display("FAIL ws_new_w: got %0d expected 13", b_psum); errors++; end
        drain = 1'b1;
        step();
        drain = 1'b0;
        step();
        checks++; if (b_vld !== 1'b0) begin
            $display("FAIL ws_drain_ignored: got %b expected 0", b_vld); errors++; end
        mode = 1'b0; psum_in = 32'd0;
        step(); step();
    endtask

    task automatic test_os_unsigned();
        a_in = 8'd3; b_in = 8'd4; a_vld_in = 1'b1;
        repeat (4) step();
        a_vld_in = 1'b0; drain = 1'b1;
        step();
        drain = 1'b0;
        step();
        checks++; if (b_vld !== 1'b1) begin
            $display("FAIL os_vld: got %b expected 1", b_vld); errors++; end
        checks++; if (b_sum !== 32'd48) begin
            $display("FAIL os_sum: got %0d expected 48", b_sum); errors++; end
        sum_rdy = 1'b1;
        step();
        sum_rdy = 1'b0;
        checks++; if ({b_vld, b_sum} !== 33'd0) begin
            $display("FAIL os_release: got vld=%b sum=%0d expected 0/0", b_vld, b_sum); errors++; end
    endtask

    task automatic test_signed();
        a_in = 8'hFE; b_in = 8'd5; a_vld_in = 1'b1;
        step();
        a_vld_in = 1'b0; drain = 1'b1;
        step();
        drain = 1'b0;
        step();
        checks++; if (s_sum !== 32'hFFFF_FFF6) begin
            $display("FAIL signed_sum: got %h expected fffffff6", s_sum); errors++; end
        checks++; if ({s_vld, s_sat} !== 2'b10) begin
            $display("FAIL signed_flags: got %b expected 10", {s_vld, s_sat}); errors++; end
        checks++; if (b_sum !== 32'd1270) begin
            $display("FAIL unsigned_fe: got %0d expected 1270", b_sum); errors++; end
        sum_rdy = 1'b1;
        step();
        sum_rdy = 1'b0;
    endtask

    task automatic test_saturate();
        a_in = 8'd255; b_in = 8'd255; a_vld_in = 1'b1;
        repeat (2) step();
        a_vld_in = 1'b0; drain = 1'b1;
        step();
        drain = 1'b0;
        step();
        checks++; if ({t_sum, t_sat} !== {16'hFFFF, 1'b1}) begin
            $display("FAIL sat16: got %h/%b expected ffff/1", t_sum, t_sat); errors++; end
        checks++; if ({w_sum, w_sat} !== {16'd64514, 1'b0}) begin
            $display("FAIL wrap16: got %0d/%b expected 64514/0", w_sum, w_sat); errors++; end
        checks++; if ({b_sum, b_sat} !== {32'd130050, 1'b0}) begin
            $display("FAIL wide_nosat: got %0d/%b expected 130050/0", b_sum, b_sat); errors++; end
        sum_rdy = 1'b1;
        step();
        sum_rdy = 1'b0;
        checks++; if ({t_sum, t_sat} !== 17'd0) begin
            $display("FAIL sat_clear: got %h/%b expected 0/0", t_sum, t_sat); errors++; end
    endtask

    task automatic test_hold_and_en();
        a_in = 8'd5; b_in = 8'd6; a_vld_in = 1'b1;
        step();
        a_vld_in = 1'b0; drain = 1'b1;
        step();
        drain = 1'b0;
        step();
        a_in = 8'd1; b_in = 8'd1; a_vld_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++; if ({b_vld, b_sum} !== {1'b1, 32'd30}) begin
                $display("FAIL hold_stable[%0d]: got vld=%b sum=%0d expected 1/30", i, b_vld, b_sum);
                errors++; end
        end
        a_in = 8'h11;
        step();
        checks++; if (ba_out !== 8'h11) begin
            $display("FAIL a_fwd: got %h expected 11", ba_out); errors++; end
        en = 1'b0; a_in = 8'h22; sum_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if ({ba_out, b_vld, b_sum} !== {8'h11, 1'b1, 32'd30}) begin
                $display("FAIL en_freeze[%0d]: got a=%h vld=%b sum=%0d expected 11/1/30",
                         i, ba_out, b_vld, b_sum);
                errors++; end
        end
        en = 1'b1; a_vld_in = 1'b0;
        step();
        sum_rdy = 1'b0;
        checks++; if ({ba_out, b_vld, b_sum} !== {8'h22, 1'b0, 32'd0}) begin
            $display("FAIL en_resume: got a=%h vld=%b sum=%0d expected 22/0/0", ba_out, b_vld, b_sum);
            errors++; end
    endtask

    task automatic test_rst_and_clr();
        a_in = 8'd3; b_in = 8'd4; a_vld_in = 1'b1;
        step();
        a_vld_in = 1'b0; drain = 1'b1;
        step();
        drain = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if ({ba_out, ba_vld, bb_out, b_psum, b_sum, b_vld, b_sat} !== 83'd0) begin
            $display("FAIL rst_flush: got sum=%0d vld=%b a=%h b=%h expected all 0",
                     b_sum, b_vld, ba_out, bb_out);
            errors++; end
        a_in = 8'd10; b_in = 8'd10; a_vld_in = 1'b1;
        step();
        a_in = 8'd2; b_in = 8'd3; acc_clr = 1'b1; drain = 1'b1;
        step();
        acc_clr = 1'b0; drain = 1'b0; a_vld_in = 1'b0;
        step();
        checks++; if ({b_sum, b_vld} !== {32'd6, 1'b0}) begin
            $display("FAIL acc_clr: got sum=%0d vld=%b expected 6/0", b_sum, b_vld); errors++; end
        step();
        checks++; if (b_vld !== 1'b0) begin
            $display("FAIL clr_over_drain: got %b expected 0", b_vld); errors++; end
        drain = 1'b1;
        step();
        drain = 1'b0;
        step();
        checks++; if ({b_vld, b_sum} !== {1'b1, 32'd6}) begin
            $display("FAIL drain_after_rst: got vld=%b sum=%0d expected 1/6", b_vld, b_sum); errors++; end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if ({b_vld, b_sum} !== 33'd0) begin
            $display("FAIL rst_hold: got vld=%b sum=%0d expected 0/0", b_vld, b_sum); errors++; end
    endtask

    initial begin
        test_reset();
        test_ws();
        test_os_unsigned();
        test_signed();
        test_saturate();
        test_hold_and_en();
        test_rst_and_clr();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
